// File: rtl/instruction_fetch_mod.sv
// Instruction fetch stage: PC register, memory address drive and IF/ID pipeline register.
// Optional macro FETCH_MISALIGN_TRAP_EN rejects misaligned redirect targets and pulses misalign_o.
module instruction_fetch_mod #(
  parameter int unsigned N        = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic         branch_taken_i,
  input  logic [N-1:0] branch_target_i,
  input  logic [31:0]  read_data_i,
  output logic [N-1:0] address_o,
  output logic [31:0]  instr_o,
  output logic [N-1:0] pc_o,
  output logic [N-1:0] pc_plus4_o,
  output logic         valid_o,
  output logic         misalign_o
);

  localparam int unsigned IW = 32;

  logic [N-1:0]  pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [N-1:0]  pc_id_q, pc_id_d;
  logic [N-1:0]  pc_plus4_q, pc_plus4_d;
  logic          valid_q, valid_d;
  logic          misalign_q, misalign_d;
  logic [N-1:0]  pc_inc;

  // Carry out of the increment is dropped so the PC wraps modulo 2^N.
  assign pc_inc = pc_q + N'(4);

  // Next-state selection: branch > flush > stall > normal fetch.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_id_d    = pc_id_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    misalign_d = 1'b0;
    if (branch_taken_i) begin
      instr_d    = '0;
      pc_id_d    = '0;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (branch_target_i[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end else begin
        pc_d = branch_target_i;
      end
`else
      pc_d = branch_target_i & ~N'(3);
`endif
    end else if (flush_i) begin
      instr_d    = '0;
      pc_id_d    = '0;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
      if (!stall_i) begin
        pc_d = pc_inc;
      end
    end else if (!stall_i) begin
      instr_d    = read_data_i;
      pc_id_d    = pc_q;
      pc_plus4_d = pc_inc;
      valid_d    = 1'b1;
      pc_d       = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= N'(RESET_PC);
      instr_q    <= '0;
      pc_id_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_id_q    <= pc_id_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign address_o  = pc_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_id_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_instruction_fetch_mod.sv
// Directed bench for instruction_fetch_mod with a combinational instruction memory model.
module tb_instruction_fetch_mod;

  localparam int unsigned N = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall_i;
  logic         flush_i;
  logic         branch_taken_i;
  logic [N-1:0] branch_target_i;
  logic [31:0]  read_data_i;
  logic [N-1:0] address_o;
  logic [31:0]  instr_o;
  logic [N-1:0] pc_o;
  logic [N-1:0] pc_plus4_o;
  logic         valid_o;
  logic         misalign_o;

  int checks   = 0;
  int failures = 0;

  instruction_fetch_mod #(.N(N), .RESET_PC(0)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .read_data_i     (read_data_i),
    .address_o       (address_o),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o),
    .valid_o         (valid_o),
    .misalign_o      (misalign_o)
  );

  always #5 clk = ~clk;

  // Memory image: fixed words at 0/4/8, address-tagged filler elsewhere.
  always_comb begin
    case (address_o)
      10'd0:   read_data_i = 32'h0000_0000;
      10'd4:   read_data_i = 32'h0000_0081;
      10'd8:   read_data_i = 32'h0800_3402;
      default: read_data_i = 32'hDEAD_0000 | 32'(address_o);
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    branch_taken_i = 1'b0; branch_target_i = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({instr_o, pc_o, pc_plus4_o, valid_o, misalign_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got instr=%h pc=%0d pc4=%0d v=%b m=%b exp all 0",
               instr_o, pc_o, pc_plus4_o, valid_o, misalign_o);
    end
    checks++;
    if (address_o !== 10'd0) begin
      failures++; $display("FAIL reset_addr got=%0d exp=0", address_o);
    end
    // Mid-run reset overrides a simultaneous branch.
    step(); step();
    rst = 1'b1; branch_taken_i = 1'b1; branch_target_i = 10'd100;
    step();
    rst = 1'b0; branch_taken_i = 1'b0;
    checks++;
    if ({address_o, instr_o, pc_o, valid_o} !== '0) begin
      failures++;
      $display("FAIL midrun_reset got addr=%0d instr=%h pc=%0d v=%b exp 0", address_o, instr_o, pc_o, valid_o);
    end
  endtask

  task automatic test_free_run();
    do_reset();
    step();
    checks++;
    if (instr_o !== 32'h0 || pc_o !== 10'd0 || valid_o !== 1'b1 || address_o !== 10'd4) begin
      failures++;
      $display("FAIL run_c1 got instr=%h pc=%0d v=%b addr=%0d exp 00000000/0/1/4", instr_o, pc_o, valid_o, address_o);
    end
    step();
    checks++;
    if (instr_o !== 32'h81 || pc_o !== 10'd4 || pc_plus4_o !== 10'd8 || address_o !== 10'd8) begin
      failures++;
      $display("FAIL run_c2 got instr=%h pc=%0d pc4=%0d addr=%0d exp 00000081/4/8/8", instr_o, pc_o, pc_plus4_o, address_o);
    end
    step();
    checks++;
    if (instr_o !== 32'h0800_3402 || pc_o !== 10'd8 || pc_plus4_o !== 10'd12 || address_o !== 10'd12) begin
      failures++;
      $display("FAIL run_c3 got instr=%h pc=%0d pc4=%0d addr=%0d exp 08003402/8/12/12", instr_o, pc_o, pc_plus4_o, address_o);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (instr_o !== 32'h81 || pc_o !== 10'd4 || valid_o !== 1'b1 || address_o !== 10'd8) begin
        failures++;
        $display("FAIL stall_hold%0d got instr=%h pc=%0d v=%b addr=%0d exp 00000081/4/1/8", i, instr_o, pc_o, valid_o, address_o);
      end
    end
    stall_i = 1'b0;
    step();
    checks++;
    if (instr_o !== 32'h0800_3402 || pc_o !== 10'd8 || address_o !== 10'd12) begin
      failures++;
      $display("FAIL stall_release got instr=%h pc=%0d addr=%0d exp 08003402/8/12", instr_o, pc_o, address_o);
    end
  endtask

  task automatic test_branch(input logic with_stall);
    do_reset();
    step(); step();
    branch_taken_i = 1'b1; branch_target_i = 10'd4; stall_i = with_stall;
    step();
    branch_taken_i = 1'b0; stall_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 10'd0 || address_o !== 10'd4) begin
      failures++;
      $display("FAIL branch_bubble stall=%b got v=%b instr=%h pc=%0d addr=%0d exp 0/0/0/4", with_stall, valid_o, instr_o, pc_o, address_o);
    end
    step();
    checks++;
    if (instr_o !== 32'h81 || pc_o !== 10'd4 || valid_o !== 1'b1 || address_o !== 10'd8) begin
      failures++;
      $display("FAIL branch_target stall=%b got instr=%h pc=%0d v=%b addr=%0d exp 00000081/4/1/8", with_stall, instr_o, pc_o, valid_o, address_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || instr_o !== 32'h0 || address_o !== 10'd8) begin
      failures++;
      $display("FAIL flush_nostall got v=%b instr=%h addr=%0d exp 0/0/8", valid_o, instr_o, address_o);
    end
    do_reset();
    step();
    flush_i = 1'b1; stall_i = 1'b1;
    step();
    flush_i = 1'b0; stall_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || instr_o !== 32'h0 || address_o !== 10'd4) begin
      failures++;
      $display("FAIL flush_stall got v=%b instr=%h addr=%0d exp 0/0/4", valid_o, instr_o, address_o);
    end
    step();
    checks++;
    if (instr_o !== 32'h81 || pc_o !== 10'd4 || valid_o !== 1'b1) begin
      failures++;
      $display("FAIL flush_stall_resume got instr=%h pc=%0d v=%b exp 00000081/4/1", instr_o, pc_o, valid_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    branch_taken_i = 1'b1; branch_target_i = 10'd1016;
    step();
    branch_taken_i = 1'b0;
    step();
    checks++;
    if (instr_o !== 32'hDEAD_03F8 || pc_o !== 10'd1016 || pc_plus4_o !== 10'd1020 || address_o !== 10'd1020) begin
      failures++;
      $display("FAIL wrap_pre got instr=%h pc=%0d pc4=%0d addr=%0d exp DEAD03F8/1016/1020/1020", instr_o, pc_o, pc_plus4_o, address_o);
    end
    step();
    checks++;
    if (instr_o !== 32'hDEAD_03FC || pc_o !== 10'd1020 || pc_plus4_o !== 10'd0 || address_o !== 10'd0) begin
      failures++;
      $display("FAIL wrap got instr=%h pc=%0d pc4=%0d addr=%0d exp DEAD03FC/1020/0/0", instr_o, pc_o, pc_plus4_o, address_o);
    end
  endtask

  task automatic test_misalign();
    logic [N-1:0] exp_addr;
    logic         exp_mis;
    logic [31:0]  exp_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_addr = 10'd8; exp_mis = 1'b1; exp_instr = 32'h0800_3402;
`else
    exp_addr = 10'd4; exp_mis = 1'b0; exp_instr = 32'h0000_0081;
`endif
    do_reset();
    step(); step();
    branch_taken_i = 1'b1; branch_target_i = 10'd6;
    step();
    branch_taken_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || misalign_o !== exp_mis || address_o !== exp_addr) begin
      failures++;
      $display("FAIL misalign_redirect got v=%b m=%b addr=%0d exp 0/%b/%0d", valid_o, misalign_o, address_o, exp_mis, exp_addr);
    end
    step();
    checks++;
    if (misalign_o !== 1'b0 || instr_o !== exp_instr || pc_o !== exp_addr || valid_o !== 1'b1) begin
      failures++;
      $display("FAIL misalign_after got m=%b instr=%h pc=%0d v=%b exp 0/%h/%0d/1", misalign_o, instr_o, pc_o, valid_o, exp_instr, exp_addr);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_branch(1'b0);
    test_branch(1'b1);
    test_flush();
    test_wrap();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
